// File: rtl/alarm_clock_pkg.sv
// Shared types and wrap-around helpers for the alarm-clock datapath.
package alarm_clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    typedef enum logic {SEL_TIME, SEL_ALARM} sel_e;
    typedef enum logic {IDLE, EDIT} edit_state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hh;
        logic [MIN_W-1:0]  mm;
    } hhmm_t;

    // Hour step, 23 wraps to 0.
    function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
        return (h == HOUR_MAX) ? '0 : h + HOUR_W'(1);
    endfunction

    // Minute/second step, 59 wraps to 0 (no carry out).
    function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
        return (m == MIN_MAX) ? '0 : m + MIN_W'(1);
    endfunction

endpackage

// File: rtl/hms_counter.sv
// Seconds prescaler plus hh:mm:ss cascade with a synchronous hh:mm load.
// sec_tick is registered: it is high in the cycle the new second is visible.
module hms_counter
    import alarm_clock_pkg::*;
#(
    parameter int CLKS_PER_SEC = 50_000_000
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  hhmm_t            load_val,
    output hhmm_t            hhmm,
    output logic [SEC_W-1:0] sec,
    output logic             sec_tick
);

    localparam int            PW     = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic          wrap;

    assign wrap = (presc == PRE_TC);

    // Load beats a coincident wrap: time restarts at hh:mm:00 with no tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            sec      <= '0;
            hhmm     <= '0;
            sec_tick <= 1'b0;
        end else if (load) begin
            presc    <= '0;
            sec      <= '0;
            hhmm     <= load_val;
            sec_tick <= 1'b0;
        end else if (wrap) begin
            presc    <= '0;
            sec_tick <= 1'b1;
            sec      <= min_inc(sec);
            if (sec == MIN_MAX) begin
                hhmm.mm <= min_inc(hhmm.mm);
                if (hhmm.mm == MIN_MAX)
                    hhmm.hh <= hour_inc(hhmm.hh);
            end
        end else begin
            presc    <= presc + PW'(1);
            sec_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/time_core.sv
// Alarm-clock datapath: running time, alarm, edit scratch register with
// auto-repeat increments, ring timer and registered display mux.
module time_core
    import alarm_clock_pkg::*;
#(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int REPEAT_CLKS  = 25_000_000,
    parameter int RING_SECS    = 60
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              showTime,
    input  logic              loadTime,
    input  logic              showAlarm,
    input  logic              loadAlarm,
    input  logic              incrHour,
    input  logic              incrMinute,
    input  logic              alarm_off,
    output logic [HOUR_W-1:0] disp_hour,
    output logic [MIN_W-1:0]  disp_min,
    output logic [SEC_W-1:0]  disp_sec,
    output logic              disp_is_alarm,
    output logic              editing,
    output logic              ring,
    output logic              sec_tick
);

    localparam int            RW     = (REPEAT_CLKS > 1) ? $clog2(REPEAT_CLKS) : 1;
    localparam logic [RW-1:0] REP_TC = RW'(REPEAT_CLKS - 1);
    localparam int            CW     = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [CW-1:0] RING_TC = CW'(RING_SECS - 1);

    hhmm_t            time_hhmm;
    logic [SEC_W-1:0] time_sec;
    hhmm_t            alarm;
    hhmm_t            edit, edit_nx, src;
    sel_e             sel;
    edit_state_e      state, state_nx;
    logic [RW-1:0]    rep_cnt, rep_nx;
    logic [CW-1:0]    ring_cnt;
    logic             ih_q, im_q;
    logic             rise_h, rise_m, held, rep_fire, ring_hit;

    hms_counter #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_hms (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (loadTime),
        .load_val (edit),
        .hhmm     (time_hhmm),
        .sec      (time_sec),
        .sec_tick (sec_tick)
    );

    assign editing  = (state == EDIT);
    assign rise_h   = incrHour & ~ih_q;
    assign rise_m   = incrMinute & ~im_q;
    assign held     = incrHour | incrMinute;
    assign rep_fire = (rep_cnt == REP_TC);
    assign src      = (sel == SEL_ALARM) ? alarm : time_hhmm;
    assign ring_hit = sec_tick && (time_sec == '0) && (time_hhmm == alarm);

    // Edit FSM next state, edit value and repeat counter.
    // Hour always wins; a minute event while incrHour is high is dropped.
    always_comb begin
        state_nx = state;
        edit_nx  = edit;
        rep_nx   = rep_cnt;
        if (state == IDLE) begin
            rep_nx = '0;
            if (held) begin
                state_nx = EDIT;
                edit_nx  = src;
                if (incrHour) edit_nx.hh = hour_inc(src.hh);
                else          edit_nx.mm = min_inc(src.mm);
            end
        end else begin
            if (showTime || showAlarm || loadTime || loadAlarm) begin
                state_nx = IDLE;
                rep_nx   = '0;
            end else if (rise_h || rise_m) begin
                rep_nx = '0;
                if (rise_h)         edit_nx.hh = hour_inc(edit.hh);
                else if (!incrHour) edit_nx.mm = min_inc(edit.mm);
            end else if (held) begin
                if (rep_fire) begin
                    rep_nx = '0;
                    if (incrHour) edit_nx.hh = hour_inc(edit.hh);
                    else          edit_nx.mm = min_inc(edit.mm);
                end else begin
                    rep_nx = rep_cnt + RW'(1);
                end
            end else begin
                rep_nx = '0;
            end
        end
    end

    // Edit FSM state, edit register, repeat counter and input edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            edit    <= '0;
            rep_cnt <= '0;
            ih_q    <= 1'b0;
            im_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            edit    <= edit_nx;
            rep_cnt <= rep_nx;
            ih_q    <= incrHour;
            im_q    <= incrMinute;
        end
    end

    // Display source select and alarm commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= SEL_TIME;
            alarm <= '0;
        end else begin
            if (showTime)       sel <= SEL_TIME;
            else if (showAlarm) sel <= SEL_ALARM;
            if (loadAlarm)      alarm <= edit;
        end
    end

    // Ring timer: only a second tick can start it, alarm_off always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring     <= 1'b0;
            ring_cnt <= '0;
        end else if (alarm_off) begin
            ring <= 1'b0;
        end else if (ring_hit) begin
            ring     <= 1'b1;
            ring_cnt <= '0;
        end else if (ring && sec_tick) begin
            if (ring_cnt == RING_TC) ring <= 1'b0;
            else                     ring_cnt <= ring_cnt + CW'(1);
        end
    end

    // Registered display mux; holds when nothing selects a source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_hour     <= '0;
            disp_min      <= '0;
            disp_sec      <= '0;
            disp_is_alarm <= 1'b0;
        end else if (showTime) begin
            disp_hour     <= time_hhmm.hh;
            disp_min      <= time_hhmm.mm;
            disp_sec      <= time_sec;
            disp_is_alarm <= 1'b0;
        end else if (showAlarm) begin
            disp_hour     <= alarm.hh;
            disp_min      <= alarm.mm;
            disp_sec      <= '0;
            disp_is_alarm <= 1'b1;
        end else if (state == EDIT) begin
            disp_hour     <= edit.hh;
            disp_min      <= edit.mm;
            disp_sec      <= '0;
            disp_is_alarm <= (sel == SEL_ALARM);
        end
    end

endmodule
